// File: rtl/mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_n
//  Description : N-channel arbitrating multiplexer with a single registered
//                output stage (valid/ready on both sides).
//                Define MUX_ARB_RR_EN for round-robin arbitration. In the
//                default build the arbiter uses fixed priority: the lowest
//                index wins, and there is no priority pointer.
//  Ports       : clk        - single clock, rising edge
//                rst        - synchronous active-high reset
//                in_data    - N packed words, channel k at [k*WIDTH +: WIDTH]
//                in_valid   - per-channel word present
//                in_ready   - one-hot grant, word accepted this cycle
//                out_data   - registered selected word
//                out_sel    - registered index of the supplying channel
//                out_valid  - output register holds a word
//                out_ready  - consumer accepts the word this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_arb_n #(
    parameter int WIDTH = 16,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    logic             w_load;
    logic             w_found;
    logic             w_xfer;
    logic [SEL_W-1:0] w_grant;
    logic [SEL_W-1:0] w_base;
    logic [WIDTH-1:0] w_grant_data;
    logic [N-1:0]     w_onehot;

    // Channel examined at search position i when position 0 is 'base'.
    function automatic int scan_idx(input int base, input int i);
        return (base + i) % N;
    endfunction

    // The output register can take a new word when empty or being drained.
    assign w_load = !r_out_valid || out_ready;

    // Priority search starting at w_base; first requester found wins.
    always_comb begin
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && in_valid[scan_idx(int'(w_base), i)]) begin
                w_found      = 1'b1;
                w_grant      = SEL_W'(scan_idx(int'(w_base), i));
                w_grant_data = in_data[scan_idx(int'(w_base), i)*WIDTH +: WIDTH];
            end
        end
    end

    // Reset gates the handshake so no word is consumed while in reset.
    assign w_xfer   = !rst && w_load && w_found;
    assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_grant;
    assign in_ready = w_xfer ? w_onehot : '0;

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] r_ptr;

    // Pointer moves one past the winner; N need not be a power of two,
    // so the wrap is explicit rather than relying on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_grant == SEL_W'(N - 1)) ? '0 : w_grant + SEL_W'(1);
        end
    end

    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    // Output register. With load high and no grant, valid falls but the
    // data/sel fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_found;
            if (w_found) begin
                r_out_data <= w_grant_data;
                r_out_sel  <= w_grant;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_arb_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_arb_n
//  Description : Scoreboard bench for mux_arb_n (N=4, WIDTH=16). Stimulus
//                pushes expected output words into a queue; a monitor pops
//                and compares whenever a word leaves the output register.
//                Expected grants follow the build: MUX_ARB_RR_EN selects the
//                round-robin table, otherwise fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_arb_n;

    localparam int WIDTH = 16;
    localparam int N     = 4;

`ifdef MUX_ARB_RR_EN
    localparam int FAIR_G [0:7] = '{0, 1, 2, 3, 0, 1, 2, 3};
    localparam int FP_G   [0:2] = '{1, 3, 1};
    localparam int BP_G         = 3;
`else
    localparam int FAIR_G [0:7] = '{0, 0, 0, 0, 0, 0, 0, 0};
    localparam int FP_G   [0:2] = '{1, 1, 1};
    localparam int BP_G         = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mux_arb_n #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [15:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    function automatic logic [15:0] ch_word(input int ch);
        return in_data[ch*WIDTH +: WIDTH];
    endfunction

    task automatic expect_word(input int ch);
        exp_t e;
        e.data = ch_word(ch);
        e.sel  = 2'(ch);
        exp_q.push_back(e);
    endtask

    // Monitor: a word leaves whenever valid and ready coincide.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %h sel %0d, expected no word", out_data, out_sel);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_out_data", 32'(out_data), 32'(mon_e.data));
                check("mon_out_sel",  32'(out_sel),  32'(mon_e.sel));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with every channel requesting.
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            settle();
            check("rst_in_ready",  32'(in_ready),  32'h0);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_out_data",  32'(out_data),  32'h0);
            check("rst_out_sel",   32'(out_sel),   32'h0);
        end

        // Single requester on channel 2.
        step();
        rst      = 1'b0;
        in_valid = 4'b0100;
        set_ch(2, 16'hBEEF);
        settle();
        check("single_in_ready", 32'(in_ready), 32'h4);
        expect_word(2);
        step();
        in_valid = 4'b0000;
        settle();
        check("single_out_valid", 32'(out_valid), 32'h1);
        step();
        settle();
        check("drain_out_valid", 32'(out_valid), 32'h0);
        check("drain_out_data",  32'(out_data),  32'hBEEF);

        // Pointer back to 0 before the fairness run.
        rst = 1'b1;
        step();
        rst = 1'b0;

        // All four channels requesting for eight cycles.
        in_valid = 4'b1111;
        for (int k = 0; k < N; k++) set_ch(k, 16'hA000 + 16'(k));
        settle();
        for (int i = 0; i < 8; i++) begin
            check("fair_in_ready", 32'(in_ready), 32'(1) << FAIR_G[i]);
            if (i > 0) check("fair_no_bubble", 32'(out_valid), 32'h1);
            expect_word(FAIR_G[i]);
            step();
            settle();
        end
        in_valid = 4'b0000;
        step();
        settle();

        // Backpressure: channel 1 word held while the consumer stalls.
        in_valid = 4'b0010;
        set_ch(1, 16'h1234);
        settle();
        check("bp_first_in_ready", 32'(in_ready), 32'h2);
        expect_word(1);
        step();
        out_ready = 1'b0;
        in_valid  = 4'b1011;
        set_ch(0, 16'h0A0A);
        set_ch(1, 16'h1B1B);
        set_ch(3, 16'h3C3C);
        settle();
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready",  32'(in_ready),  32'h0);
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_out_data",  32'(out_data),  32'h1234);
            check("bp_out_sel",   32'(out_sel),   32'h1);
            step();
            settle();
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_in_ready", 32'(in_ready), 32'(1) << BP_G);
        expect_word(BP_G);
        step();
        in_valid = 4'b0000;
        step();
        settle();

        // Channels 1 and 3 competing for three cycles.
        in_valid = 4'b1010;
        set_ch(1, 16'h5151);
        set_ch(3, 16'h5353);
        settle();
        for (int i = 0; i < 3; i++) begin
            check("fp_in_ready", 32'(in_ready), 32'(1) << FP_G[i]);
            expect_word(FP_G[i]);
            step();
            settle();
        end
        in_valid = 4'b0000;
        step();
        settle();

        // Mid-stream reset with a word held in the output register.
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        set_ch(2, 16'h7777);
        settle();
        check("mrst_grant_in_ready", 32'(in_ready), 32'h4);
        step();
        in_valid = 4'b0000;
        settle();
        check("mrst_held_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        settle();
        check("mrst_in_ready", 32'(in_ready), 32'h0);
        step();
        settle();
        check("mrst_out_valid", 32'(out_valid), 32'h0);
        check("mrst_out_data",  32'(out_data),  32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1001;
        set_ch(0, 16'h8080);
        set_ch(3, 16'h8383);
        settle();
        check("mrst_first_in_ready", 32'(in_ready), 32'h1);
        expect_word(0);
        step();
        in_valid = 4'b0000;
        step();
        step();
        settle();

        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width per channel in bits.
REQ-002 SHALL have parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 SHALL derive localparam SEL_W = $clog2(N), the channel index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  N  bit k set when channel k presents a word.
REQ-008 SHALL have port in_ready  output  N  bit k set when channel k's word is accepted this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  registered selected word.
REQ-010 SHALL have port out_sel  output  SEL_W  registered index of the channel that supplied out_data.
REQ-011 SHALL have port out_valid  output  1  out_data/out_sel hold a word.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word this cycle.

Function
REQ-013 SHALL hold one output register (out_data, out_sel, out_valid).
REQ-014 SHALL define load = !out_valid || out_ready; a new word is captured only when load is high.
REQ-015 SHALL, when load is high and any in_valid bit is set, grant exactly one channel g, drive in_ready = one-hot(g), and capture in_data[g] and g on the next edge with out_valid = 1.
REQ-016 SHALL drive in_ready to all zeros when load is low or no in_valid bit is set; in_ready may depend combinationally on in_valid and out_ready.
REQ-017 SHALL define a transfer on channel k as in_valid[k] && in_ready[k]; an input word is consumed only on a transfer.
REQ-018 SHALL give a latency of one cycle from an input transfer to out_valid.
REQ-019 SHALL clear out_valid on an edge where out_valid && out_ready and no channel is granted.
REQ-020 SHALL sustain one word per cycle: when out_valid && out_ready and a channel is granted in the same cycle, replace the word with no bubble.
REQ-021 SHALL hold out_data and out_sel stable while out_valid && !out_ready.
REQ-022 SHALL select a winner by round-robin: a priority pointer p (SEL_W bits) names the highest-priority channel, and search runs p, p+1, ... N-1, 0, ... p-1.
REQ-023 SHALL update p to (g+1) mod N after each transfer; wrap from N-1 to 0; p is unchanged on cycles without a transfer.
REQ-024 SHALL, with a single requester, grant it regardless of p.
REQ-025 SHALL leave out_data unchanged when out_valid drops; only out_valid signals validity.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set out_valid = 0, out_data = 0, out_sel = 0 and p = 0.
REQ-027 SHALL drive in_ready to all zeros while rst is high; a word held in the output register is discarded.
REQ-028 SHALL allow rst to be asserted mid-stream; the first grant after release uses p = 0.

Configuration
REQ-029 SHALL, with macro MUX_ARB_RR_EN defined, arbitrate by round-robin per REQ-022/REQ-023.
REQ-030 SHALL, without MUX_ARB_RR_EN, arbitrate by fixed priority, lowest index wins, and omit pointer p; all other requirements are unchanged.

Verification
REQ-031 SHALL cover reset: rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-032 SHALL cover single channel: N=4, WIDTH=16, in_valid=4'b0100, in_data ch2=16'hBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=16'hBEEF, out_sel=2.
REQ-033 SHALL cover round-robin fairness: in_valid=4'b1111 for 8 cycles, out_ready=1, RR_EN defined -> grants 0,1,2,3,0,1,2,3, one per cycle, no bubbles.
REQ-034 SHALL cover backpressure: word from ch1=16'h1234 held, out_ready=0 for 5 cycles with in_valid=4'b1011 -> in_ready=0, out_data=16'h1234 and out_sel=1 stable; on out_ready=1 -> ch3 granted (p=2).
REQ-035 SHALL cover fixed priority: RR_EN undefined, in_valid=4'b1010 for 3 cycles -> ch1 granted every cycle, ch3 never.
REQ-036 SHALL cover mid-stream reset: rst pulsed while out_valid=1 and p=3 -> out_valid=0 next cycle; after release with in_valid=4'b1001 -> ch0 granted first.
